// File: rtl/ram.sv
// ram -- word-organised single-port data memory for the nanosoc load/store path.
//
// Storage is a DEPTH x 32 flop array so the asynchronous reset can clear every
// word at once. Writes land on the rising clock edge; reads are combinational.
// A write-through bypass returns the write data in the same cycle.
//
// Ports:
//   clk     in   1   system clock, writes on rising edge
//   rst_    in   1   asynchronous active-low reset, clears the whole array
//   we_i    in   1   write enable
//   addr_i  in  32   byte address, word index = addr_i[AW+1:2]
//   data_i  in  32   write data
//   data_o  out 32   read data for addr_i
module ram #(
   parameter int DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst_,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]   r_mem [DEPTH];

   logic [AW-1:0] w_idx;
   logic          w_in_range;
   logic          w_wr;
   logic          w_unused_lsbs;

   assign w_idx      = addr_i[AW+1:2];
   // Any set bit above the word index means the access is past the array;
   // such accesses neither write nor alias onto a lower word.
   assign w_in_range = ~|addr_i[31:AW+2];
   // An X on we_i makes w_wr X, which the if below treats as false, so an
   // unknown enable never corrupts a word in simulation.
   assign w_wr       = we_i & w_in_range;

   // Byte-offset bits play no part in word addressing.
   assign w_unused_lsbs = ^addr_i[1:0];

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 32'h0;
         end
      end else if (w_wr) begin
         r_mem[w_idx] <= data_i;
      end
   end

   always_comb begin
      data_o = 32'h0;
      if (rst_ && w_in_range) begin
         // Bypass keeps read-during-write independent of edge ordering.
         if (we_i) data_o = data_i;
         else      data_o = r_mem[w_idx];
      end
   end

endmodule

// File: tb/tb_ram.sv
module tb_ram;

   logic        clk;
   logic        rst_;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;

   int tests  = 0;
   int failed = 0;

   ram #(.DEPTH(256)) dut (
      .clk    (clk),
      .rst_   (rst_),
      .we_i   (we_i),
      .addr_i (addr_i),
      .data_i (data_i),
      .data_o (data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] exp);
      tests++;
      assert (data_o === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, data_o, exp);
      end
   endtask

   // Write one word across a single rising edge, starting from the falling edge.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      addr_i = a;
      data_i = d;
      we_i   = 1'b1;
      @(posedge clk);
      #1;
      we_i   = 1'b0;
   endtask

   // Combinational read, sampled 1 time unit after driving the address.
   task automatic rd(input logic [31:0] a);
      we_i   = 1'b0;
      addr_i = a;
      #1;
   endtask

   initial begin
      rst_   = 1'b0;
      we_i   = 1'b0;
      addr_i = 32'h0;
      data_i = 32'h0;

      // Reset state
      rd(32'h0);   check("rst_rd_0x0",   32'h0);
      rd(32'h8);   check("rst_rd_0x8",   32'h0);
      rd(32'h3FC); check("rst_rd_0x3FC", 32'h0);

      // Writes during reset are ignored and do not show on data_o
      wr(32'h8, 32'h12345678);
      check("rst_wr_ignored", 32'h0);

      // Release reset between edges
      @(negedge clk);
      #2 rst_ = 1'b1;
      rd(32'h8); check("post_rst_rd_0x8", 32'h0);

      // Write-through and storage
      @(negedge clk);
      addr_i = 32'h8; data_i = 32'h42; we_i = 1'b1;
      #1 check("bypass_0x8", 32'h42);
      @(posedge clk);
      #1 check("after_edge_0x8", 32'h42);
      we_i = 1'b0;
      #1 check("stored_0x8", 32'h42);

      wr(32'h0, 32'h11111111);
      wr(32'h4, 32'h22222222);
      rd(32'h0); check("rd_0x0", 32'h11111111);
      rd(32'h4); check("rd_0x4", 32'h22222222);
      rd(32'h8); check("rd_0x8", 32'h42);
      rd(32'h9); check("rd_0x9_lsb_ignored", 32'h42);
      rd(32'h7); check("rd_0x7_lsb_ignored", 32'h22222222);

      // Last word in range
      wr(32'h3FC, 32'h5555AAAA);
      rd(32'h3FC); check("rd_0x3FC_last", 32'h5555AAAA);
      rd(32'h0);   check("rd_0x0_after_last", 32'h11111111);

      // Reset mid-cycle clears immediately and whole array
      rd(32'h8);
      @(negedge clk);
      #2 rst_ = 1'b0;
      #1 check("async_rst_immediate", 32'h0);
      #2 rst_ = 1'b1;
      rd(32'h8);   check("cleared_0x8",   32'h0);
      rd(32'h0);   check("cleared_0x0",   32'h0);
      rd(32'h3FC); check("cleared_0x3FC", 32'h0);

      // Out of range: no write, no aliasing onto word 0, read returns 0
      wr(32'h0, 32'h11111111);
      @(negedge clk);
      addr_i = 32'h400; data_i = 32'hDEADBEEF; we_i = 1'b1;
      #1 check("oor_bypass_0x400", 32'h0);
      @(posedge clk);
      #1 we_i = 1'b0;
      #1 check("oor_rd_0x400", 32'h0);
      rd(32'h0);        check("no_alias_0x0", 32'h11111111);
      rd(32'h80000000); check("oor_rd_high", 32'h0);

      // Unknown write enable is treated as no write
      @(negedge clk);
      addr_i = 32'h4; data_i = 32'hBAD0BAD0; we_i = 1'bx;
      @(posedge clk);
      #1 we_i = 1'b0;
      rd(32'h4); check("x_we_no_write", 32'h0);

      // Back-to-back writes on consecutive edges
      @(negedge clk);
      addr_i = 32'h10; data_i = 32'hA; we_i = 1'b1;
      @(negedge clk);
      data_i = 32'hB;
      @(posedge clk);
      #1 we_i = 1'b0;
      rd(32'h10); check("b2b_final_0x10", 32'hB);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ram.md
Name: ram

Overview:
- Word-organised data memory for the nanosoc core.
- Writes are synchronous; reads are combinational with write-through.
- Asynchronous active-low reset clears the entire array, so memory contents are deterministic after reset.
- Sits on the core's load/store path as a single-port 32-bit memory.

Parameters:
- DEPTH, 256, number of 32-bit words (power of two, >= 4).
- AW, log2(DEPTH) = 8, word-index width derived from DEPTH.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst_  input  1  asynchronous active-low reset.
- we_i  input  1  write enable; 1 = write data_i at addr_i on the next rising clk.
- addr_i  input  32  byte address; word index = addr_i[AW+1:2]; addr_i[1:0] ignored.
- data_i  input  32  write data.
- data_o  output  32  read data for addr_i.

Behaviour:
- Interface: one clock (clk); reset rst_ is asynchronous and active-low.
- Storage: DEPTH x 32-bit registers (flop array, not an inferred RAM macro), because of the whole-array clear.
- Reset:
  - While rst_ == 0, every word is cleared to 32'h0 immediately, without waiting for a clock edge.
  - While rst_ == 0, data_o = 32'h0 and writes are ignored.
  - Deassertion of rst_ is synchronised to no particular edge; the first write is accepted on the first rising clk with rst_ == 1.
- Write:
  - On rising clk with rst_ == 1 and we_i == 1, mem[idx] <= data_i.
  - Write latency: 1 edge. No byte enables; full-word writes only.
- Out-of-range addresses:
  - When addr_i >= 4*DEPTH (any of addr_i[31:AW+2] nonzero), writes are dropped and data_o = 32'h0.
  - There is no aliasing or wrap-around.
- Read (combinational, zero latency):
  - rst_ == 0 -> 0.
  - Out of range -> 0.
  - we_i == 1 -> data_i (write-through bypass; makes read-during-write return the new data in the same cycle, independent of edge ordering).
  - Otherwise -> mem[idx].
- Reset mid-operation: an assertion of rst_ coincident with a write edge wins; the word ends at 0.
- X handling: an unknown we_i must not corrupt memory in simulation; treat X as no write.
- No handshake; the memory is always ready.

Test Plan:
- Reset, then read each of byte addresses 0x0, 0x8 and 0x3FC with we_i = 0 -> data_o = 32'h0.
- Release rst_; set addr_i = 0x8, data_i = 32'h42, we_i = 1 across a rising edge -> data_o = 32'h42 within that cycle and after the edge. Drop we_i -> data_o stays 32'h42.
- Write 0x11111111 to 0x0 and 0x22222222 to 0x4; read 0x0, 0x4 and 0x8 -> 0x11111111, 0x22222222, 0x42. Read 0x9 -> 0x42 (low address bits ignored).
- With 0x42 stored at 0x8, assert rst_ = 0 between clock edges -> data_o = 0 immediately. Deassert and read 0x8 -> 32'h0 (array cleared).
- Write 0xDEADBEEF to 0x400 (out of range for DEPTH = 256) -> data_o = 0 at 0x400. Read 0x0 -> unchanged (no aliasing).
- Back-to-back writes of 0xA then 0xB to 0x10 on consecutive edges -> final read of 0x10 = 0xB.
